zjh_dff_bank_ctrl: RTL and testbench
====================================

Name: zjh_dff_bank_ctrl

Overview:
Command-driven sequencer for a bank of WIDTH 74HC74-style D flip-flops. Each flip-flop has an active-low async preset (Sd), an active-low async clear (Rd), D and a common clock.
The block turns single commands (LOAD, PRESET, CLEAR, TOGGLE) into correctly timed Sd/Rd pulses, D setup and a one-cycle capture strobe for the bank.
It sits between the host logic and the flip-flop bank. It is the only driver of the bank's control pins.

Parameters:
WIDTH, 4, number of flip-flops in the bank (1..16).
PULSE_CYC, 2, cycles the Sd/Rd pulse is held low (>=1).
RECOV_CYC, 1, recovery cycles after the pulse before done (>=0; 0 skips RECOVER).

Ports:
Clk  in  1  system clock, rising edge.
Rd  in  1  asynchronous active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE.
cmd_op  in  2  00 LOAD, 01 PRESET, 10 CLEAR, 11 TOGGLE.
cmd_mask  in  WIDTH  bits affected.
cmd_data  in  WIDTH  LOAD data.
ff_sd  out  WIDTH  active-low preset to bank.
ff_rd  out  WIDTH  active-low clear to bank.
ff_d  out  WIDTH  D inputs to bank.
ff_ce  out  1  one-cycle capture strobe for the bank clock.
ff_q  in  WIDTH  bank Q outputs.
busy  out  1  high when not IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  readback mismatch, valid with done.

Behaviour:
- Clocking and reset: single clock Clk. Rd is asynchronous, active-high.
- Values forced while Rd=1: state=IDLE, ff_sd and ff_rd all 1 (inactive), ff_d=0, ff_ce=0, done=0, err=0, busy=0, cmd_ready=1 once Rd releases.
- Output registration: all outputs are registered, so no combinational glitches reach the bank's async pins.
- Handshake: a command is accepted on a Clk edge with cmd_valid&&cmd_ready. op, mask and data are latched, and ff_q is snapshotted as q0. Inputs are ignored in every other state.
- FSM states: IDLE, SETUP, CAPTURE, PULSE, RECOVER, DONE (plus VERIFY, see below).
- LOAD / TOGGLE path: IDLE -> SETUP (1 cycle) -> CAPTURE (1 cycle) -> DONE.
- LOAD / TOGGLE D value: ff_d is registered on entry to SETUP and held through CAPTURE.
  - LOAD: ff_d = (data & mask) | (q0 & ~mask).
  - TOGGLE: ff_d = q0 ^ mask.
- LOAD / TOGGLE strobe: ff_ce=1 during CAPTURE only.
- PRESET / CLEAR path: IDLE -> PULSE (PULSE_CYC cycles) -> RECOVER (RECOV_CYC cycles, skipped if 0) -> DONE.
- PRESET / CLEAR pulses: during PULSE, ff_sd = ~mask (PRESET) or ff_rd = ~mask (CLEAR); the other vector stays all 1. ff_sd and ff_rd are never low on the same bit. ff_ce=0 throughout.
- DONE: done=1 for exactly one cycle, then IDLE. A new command can be accepted on the cycle after DONE.
- Latency from the accept edge k (without the optional feature):
  - LOAD/TOGGLE: ff_ce high in cycle k+2, done in cycle k+3.
  - PRESET/CLEAR: pulse in cycles k+1..k+PULSE_CYC, done in cycle k+PULSE_CYC+RECOV_CYC+1.
- Pulse counter: width $clog2(PULSE_CYC+RECOV_CYC+1). It reloads on each state entry and counts down to 0.
- mask=0: the command is still accepted and the full sequence runs with the same latency. No Sd/Rd bit goes low. LOAD/TOGGLE still pulse ff_ce with ff_d=q0, so the bank is unchanged.
- Reset mid-operation: pulses end immediately, pins return inactive, no done is produced, and the command is lost.
- cmd_valid held high continuously: exactly one command is taken per sequence.
- err: 0 unless ZJH_DFF_READBACK_EN is defined.

Optional Feature:
ZJH_DFF_READBACK_EN.
- When defined: a VERIFY state (1 cycle) is inserted before DONE, adding +1 cycle to all latencies. In VERIFY, ff_q is sampled and compared against the expected value; err is registered and presented with done.
  - LOAD/TOGGLE expect the ff_d value.
  - PRESET expects q0|mask.
  - CLEAR expects q0&~mask.
- When not defined: no VERIFY state, err is tied to 0, and latencies are as stated above.

Test Plan:
1. Reset, then WIDTH=4, PULSE_CYC=2, RECOV_CYC=1, PRESET mask=4'b0101 accepted at k -> ff_sd=4'b1010 in k+1..k+2, ff_rd=4'hF throughout, done at k+4, bank model Q=4'b0101.
2. Bank Q=4'b0101, LOAD data=4'b1010 mask=4'b0011 -> ff_d=4'b0110 held in k+1..k+2, ff_ce=1 only at k+2, done at k+3, Q=4'b0110.
3. Bank Q=4'b0110, TOGGLE mask=4'hF -> ff_d=4'b1001, Q=4'b1001. Then CLEAR mask=0 -> no ff_rd bit low, done at k+4, Q unchanged.
4. Rd asserted during the second PULSE cycle of CLEAR mask=4'hF -> ff_rd=4'hF in the same cycle (async), no done, cmd_ready=1 after release, next command runs normally.
5. cmd_valid held high with back-to-back LOADs -> each accepted only in IDLE, one done per command, cmd_ready low while busy=1.
6. With ZJH_DFF_READBACK_EN and the bank model forced to hold bit0 stuck at 0 -> PRESET mask=4'h1 gives err=1 with done at k+5. A fault-free run gives err=0.

Source files
------------

// File: rtl/zjh_dff_bank_ctrl.sv
// zjh_dff_bank_ctrl
// Command sequencer for a bank of 74HC74-style D flip-flops.
// It converts LOAD / PRESET / CLEAR / TOGGLE commands into timed Sd/Rd pulses,
// D setup and a one-cycle capture strobe. Every pin that reaches the bank is
// driven straight from a flop, so the asynchronous Sd/Rd inputs never see
// combinational glitches.
//
// Optional build macro: ZJH_DFF_READBACK_EN
//   When defined, a VERIFY cycle before DONE compares the bank Q outputs with
//   the expected result and reports a mismatch on err together with done.
//   When undefined, there is no VERIFY state and err is tied low.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for cmd_valid; cmd_ready high
// SETUP   | ff_d driven with the LOAD/TOGGLE value
// CAPTURE | ff_d held, ff_ce high for the bank clock
// PULSE   | Sd or Rd held low on the masked bits for PULSE_CYC cycles
// RECOVER | pins inactive for RECOV_CYC cycles before completion
// VERIFY  | (readback build only) compare ff_q against the expected value
// DONE    | done high for one cycle, then back to IDLE

module zjh_dff_bank_ctrl #(
    parameter int WIDTH     = 4,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 1
) (
    input  logic             Clk,
    input  logic             Rd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] ff_sd,
    output logic [WIDTH-1:0] ff_rd,
    output logic [WIDTH-1:0] ff_d,
    output logic             ff_ce,
    input  logic [WIDTH-1:0] ff_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(PULSE_CYC + RECOV_CYC + 1);

    // Counter reload values: the counter runs from N-1 down to 0, giving N cycles.
    localparam logic [CW-1:0] L_PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] L_RECOV_LD = CW'((RECOV_CYC > 0) ? (RECOV_CYC - 1) : 0);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_PRESET = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

`ifdef ZJH_DFF_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PULSE   = 3'd3,
        S_RECOVER = 3'd4,
        S_VERIFY  = 3'd5,
        S_DONE    = 3'd6
    } state_t;
    // Sequences finish through VERIFY, which raises done on its way out.
    localparam state_t S_POST     = S_VERIFY;
    localparam logic   L_DONE_NOW = 1'b0;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PULSE   = 3'd3,
        S_RECOVER = 3'd4,
        S_DONE    = 3'd6
    } state_t;
    localparam state_t S_POST     = S_DONE;
    localparam logic   L_DONE_NOW = 1'b1;
`endif

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sd;
    logic [WIDTH-1:0] r_rd;
    logic [WIDTH-1:0] r_d;
    logic             r_ce;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    // ff_q at the accept edge is the q0 snapshot; the D values derive from it.
    logic [WIDTH-1:0] w_load_d;
    logic [WIDTH-1:0] w_toggle_d;

    assign w_load_d   = (cmd_data & cmd_mask) | (ff_q & ~cmd_mask);
    assign w_toggle_d = ff_q ^ cmd_mask;

`ifdef ZJH_DFF_READBACK_EN
    logic [WIDTH-1:0] r_exp;
    logic             r_err;

    // Expected bank contents, captured with the command and checked in VERIFY.
    always_ff @(posedge Clk or posedge Rd) begin
        if (Rd) begin
            r_exp <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                case (cmd_op)
                    OP_LOAD:   r_exp <= w_load_d;
                    OP_TOGGLE: r_exp <= w_toggle_d;
                    OP_PRESET: r_exp <= ff_q | cmd_mask;
                    default:   r_exp <= ff_q & ~cmd_mask;
                endcase
            end
            if (r_state == S_VERIFY) begin
                r_err <= (ff_q != r_exp);
            end else if (r_state == S_DONE) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Main sequencer with all bank and handshake outputs registered.
    always_ff @(posedge Clk or posedge Rd) begin
        if (Rd) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sd    <= '1;
            r_rd    <= '1;
            r_d     <= '0;
            r_ce    <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ce   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        case (cmd_op)
                            OP_LOAD: begin
                                r_d     <= w_load_d;
                                r_state <= S_SETUP;
                            end
                            OP_TOGGLE: begin
                                r_d     <= w_toggle_d;
                                r_state <= S_SETUP;
                            end
                            OP_PRESET: begin
                                r_sd    <= ~cmd_mask;
                                r_cnt   <= L_PULSE_LD;
                                r_state <= S_PULSE;
                            end
                            default: begin
                                r_rd    <= ~cmd_mask;
                                r_cnt   <= L_PULSE_LD;
                                r_state <= S_PULSE;
                            end
                        endcase
                    end
                end
                S_SETUP: begin
                    r_ce    <= 1'b1;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_done  <= L_DONE_NOW;
                    r_state <= S_POST;
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_sd <= '1;
                        r_rd <= '1;
                        if (RECOV_CYC == 0) begin
                            r_done  <= L_DONE_NOW;
                            r_state <= S_POST;
                        end else begin
                            r_cnt   <= L_RECOV_LD;
                            r_state <= S_RECOVER;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == '0) begin
                        r_done  <= L_DONE_NOW;
                        r_state <= S_POST;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
`ifdef ZJH_DFF_READBACK_EN
                S_VERIFY: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_sd    <= '1;
                    r_rd    <= '1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ff_sd     = r_sd;
    assign ff_rd     = r_rd;
    assign ff_d      = r_d;
    assign ff_ce     = r_ce;

endmodule

// File: tb/tb_zjh_dff_bank_ctrl.sv
// Directed bench for zjh_dff_bank_ctrl with a behavioural 74HC74 bank model.
// Outputs are sampled 1 ns after the rising edge; cycle n means the cycle
// following accept edge k+n-1 (cycle 1 is the first cycle after acceptance).

module tb_zjh_dff_bank_ctrl;

`ifdef ZJH_DFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_PRESET = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic       Clk = 1'b0;
    logic       Rd  = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op   = 2'b00;
    logic [3:0] cmd_mask = 4'h0;
    logic [3:0] cmd_data = 4'h0;
    logic [3:0] ff_sd, ff_rd, ff_d, ff_q;
    logic       ff_ce, busy, done, err;

    logic [3:0] bank_q = 4'b0000;
    logic [3:0] stuck  = 4'b0000;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 Clk = ~Clk;

    zjh_dff_bank_ctrl #(.WIDTH(4), .PULSE_CYC(2), .RECOV_CYC(1)) dut (
        .Clk(Clk), .Rd(Rd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
        .ff_sd(ff_sd), .ff_rd(ff_rd), .ff_d(ff_d), .ff_ce(ff_ce), .ff_q(ff_q),
        .busy(busy), .done(done), .err(err)
    );

    // Bank model: async preset/clear win over the clocked capture.
    always @(posedge Clk) begin
        if ((~ff_sd | ~ff_rd) != 4'h0)
            bank_q <= (bank_q | ~ff_sd) & ff_rd;
        else if (ff_ce)
            bank_q <= ff_d;
    end
    assign ff_q = bank_q & ~stuck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Present a command for one accept edge; returns in cycle 1.
    task automatic issue(input logic [1:0] op, input logic [3:0] m, input logic [3:0] d);
        cmd_op = op; cmd_mask = m; cmd_data = d; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Step from cycle 'cur' until done (bounded), check when it came and the
    // single-cycle pulse, and leave the bench in the following IDLE cycle.
    task automatic wait_done(input string tag, input int cur, input int exp_at, input logic exp_err);
        int c;
        c = cur;
        while (!done && c < cur + 20) begin
            step();
            c++;
        end
        chk({tag, "_done_at"}, c, exp_at);
        chk({tag, "_err"}, err, exp_err);
        step();
        chk({tag, "_done_1cyc"}, done, 1'b0);
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        // Reset values while Rd is held.
        step(); step();
        chk("rst_sd", ff_sd, 4'hF);
        chk("rst_rd", ff_rd, 4'hF);
        chk("rst_d", ff_d, 4'h0);
        chk("rst_ce", ff_ce, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        Rd = 1'b0;
        step();
        chk("rst_ready", cmd_ready, 1'b1);

        // 1: PRESET mask 0101.
        issue(OP_PRESET, 4'b0101, 4'h0);
        chk("t1_sd_c1", ff_sd, 4'b1010);
        chk("t1_rd_c1", ff_rd, 4'hF);
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready", cmd_ready, 1'b0);
        chk("t1_ce", ff_ce, 1'b0);
        step();
        chk("t1_sd_c2", ff_sd, 4'b1010);
        chk("t1_rd_c2", ff_rd, 4'hF);
        step();
        chk("t1_sd_c3", ff_sd, 4'hF);
        chk("t1_done_c3", done, 1'b0);
        wait_done("t1", 3, 4 + RB, 1'b0);
        chk("t1_q", ff_q, 4'b0101);

        // 2: LOAD data 1010 mask 0011 over Q=0101.
        issue(OP_LOAD, 4'b0011, 4'b1010);
        chk("t2_d_c1", ff_d, 4'b0110);
        chk("t2_ce_c1", ff_ce, 1'b0);
        step();
        chk("t2_d_c2", ff_d, 4'b0110);
        chk("t2_ce_c2", ff_ce, 1'b1);
        wait_done("t2", 2, 3 + RB, 1'b0);
        chk("t2_q", ff_q, 4'b0110);

        // 3: TOGGLE all, then CLEAR with an empty mask.
        issue(OP_TOGGLE, 4'hF, 4'h0);
        chk("t3_d", ff_d, 4'b1001);
        wait_done("t3t", 1, 3 + RB, 1'b0);
        chk("t3t_q", ff_q, 4'b1001);
        issue(OP_CLEAR, 4'h0, 4'h0);
        chk("t3c_rd_c1", ff_rd, 4'hF);
        step();
        chk("t3c_rd_c2", ff_rd, 4'hF);
        chk("t3c_sd_c2", ff_sd, 4'hF);
        wait_done("t3c", 2, 4 + RB, 1'b0);
        chk("t3c_q", ff_q, 4'b1001);

        // 4: reset during the second pulse cycle of CLEAR mask F.
        issue(OP_CLEAR, 4'hF, 4'h0);
        chk("t4_rd_c1", ff_rd, 4'h0);
        step();
        chk("t4_rd_c2", ff_rd, 4'h0);
        Rd = 1'b1;
        #1;
        chk("t4_rd_async", ff_rd, 4'hF);
        chk("t4_busy_rst", busy, 1'b0);
        step();
        chk("t4_done_rst", done, 1'b0);
        Rd = 1'b0;
        step();
        chk("t4_ready_rel", cmd_ready, 1'b1);
        chk("t4_done_rel", done, 1'b0);
        issue(OP_LOAD, 4'hF, 4'b0101);
        chk("t4_d", ff_d, 4'b0101);
        wait_done("t4", 1, 3 + RB, 1'b0);
        chk("t4_q", ff_q, 4'b0101);

        // 5: cmd_valid held high over two back-to-back LOADs.
        begin
            int p;
            int ph;
            int n_done;
            p = 4 + RB;
            n_done = 0;
            cmd_op = OP_LOAD; cmd_mask = 4'hF; cmd_data = 4'b1100; cmd_valid = 1'b1;
            step();
            cmd_data = 4'b0011;
            for (int c = 1; c <= 2 * p; c++) begin
                ph = (c - 1) % p;
                chk("t5_busy", busy, (ph != p - 1));
                chk("t5_ready", cmd_ready, (ph == p - 1));
                chk("t5_done", done, (ph == p - 2));
                if (done) n_done++;
                if (c == 1) chk("t5_d1", ff_d, 4'b1100);
                if (c == p + 1) chk("t5_d2", ff_d, 4'b0011);
                if (c == 2 * p) cmd_valid = 1'b0;
                step();
            end
            chk("t5_ndone", n_done, 2);
            chk("t5_no_third", busy, 1'b0);
            chk("t5_q", ff_q, 4'b0011);
        end

        // 6: bit0 stuck low; only the readback build flags it.
        stuck = 4'b0001;
        issue(OP_PRESET, 4'h1, 4'h0);
        wait_done("t6s", 1, 4 + RB, (RB == 1));
        stuck = 4'b0000;
        issue(OP_PRESET, 4'h4, 4'h0);
        wait_done("t6g", 1, 4 + RB, 1'b0);
        chk("t6_q", ff_q, 4'b0111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
